// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: steps a small combinational function through every input
// combination in ascending order, samples it after a programmable settle
// time, and presents the captured truth table with a compare result on a
// valid/ready port.
module kmap_sweep_ctrl #(
    parameter int NBITS  = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_val,
    output logic                  start_rdy,
    input  logic [2**NBITS-1:0]   exp_tt,
    output logic [NBITS-1:0]      in_bits,
    input  logic                  f,
    output logic                  tt_val,
    input  logic                  tt_rdy,
    output logic [2**NBITS-1:0]   tt,
    output logic                  match,
    output logic                  busy
);

    localparam int TT_W  = 2**NBITS;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TT_W-1:0]    tt_q;
    logic [TT_W-1:0]    tt_upd;
    logic [TT_W-1:0]    exp_q;
    logic [NBITS-1:0]   in_bits_q;
    logic               match_q;
    logic               accept;
    logic               sample;
    logic               last;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state and handshake/status decode
    always_comb begin
        state_d   = state_q;
        start_rdy = 1'b0;
        busy      = 1'b0;
        tt_val    = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                start_rdy = 1'b1;
                if (start_val) begin
                    accept  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                busy   = 1'b1;
                sample = (cnt_q == CNT_W'(SETTLE - 1));
                last   = sample && (idx_q == NBITS'(TT_W - 1));
                if (last) state_d = DONE;
            end
            DONE: begin
                tt_val = 1'b1;
                if (tt_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // table with the current combination's sample merged in; lets match be
    // registered from the complete table on the same edge the last bit lands
    always_comb begin
        tt_upd        = tt_q;
        tt_upd[idx_q] = f;
    end

    // sweep datapath: index, settle counter, table capture and compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            tt_q      <= '0;
            exp_q     <= '0;
            in_bits_q <= '0;
            match_q   <= 1'b0;
        end else if (accept) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            tt_q      <= '0;
            exp_q     <= exp_tt;
            in_bits_q <= '0;
            match_q   <= 1'b0;
        end else if (busy) begin
            if (sample) begin
                tt_q  <= tt_upd;
                cnt_q <= '0;
                if (last) begin
                    in_bits_q <= '0;
                    match_q   <= (tt_upd == exp_q);
                end else begin
                    idx_q     <= idx_q + NBITS'(1);
                    in_bits_q <= idx_q + NBITS'(1);
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_bits = in_bits_q;
    assign tt      = tt_q;
    assign match   = match_q;

endmodule
